ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
// Receives PS/2 keyboard frames on ps2_clk/ps2_data and turns arrow-key make/break codes into held
// button levels (key_right/key_up/key_left). These replace the board pushbuttons at the game inputs.
// It also exports the last scancode and error pulses for the LED debug bank.
// Device-to-host only; the block never drives the PS/2 lines.
// PARAMETERS
// FILTER_LEN      8       consecutive identical synced samples required before a PS/2 line level is accepted
// TIMEOUT_CYCLES  200000  clk cycles without a filtered ps2_clk fall mid-frame before the frame is aborted (2 ms @100 MHz)
// PORTS
// clk            in   1  system clock, 100 MHz
// reset          in   1  synchronous, active-high reset
// ps2_clk        in   1  PS/2 clock pin, asynchronous, idles high
// ps2_data       in   1  PS/2 data pin, asynchronous, idles high
// scancode       out  8  last correctly received byte, including E0/F0; held until next valid byte
// scancode_valid out  1  1-cycle pulse when scancode updates
// parity_err     out  1  1-cycle pulse, odd-parity mismatch
// frame_err      out  1  1-cycle pulse, bad stop bit or timeout
// key_right      out  1  level, high while E0 74 is held
// key_left       out  1  level, high while E0 6B is held
// key_up         out  1  level, high while E0 75 is held
// BEHAVIOUR
// - Reset: every output 0, FSM IDLE, all counters 0, ext/brk flags 0, filtered line levels 1.
// - Input conditioning: each pin goes through a 2-FF synchroniser, then a filter.
//   The filtered level changes only after FILTER_LEN consecutive equal synced samples that differ from it.
// - fall = filtered ps2_clk was 1 last cycle and is 0 this cycle. Data is sampled as filtered ps2_data in the fall cycle.
// - FSM IDLE:   on fall, if data==0 go to DATA and set bit_cnt=0; if data==1, stay in IDLE and raise no flag.
// - FSM DATA:   on each fall, shift data in LSB first. After the 8th bit go to PARITY.
// - FSM PARITY: on fall, latch the parity bit and go to STOP.
// - FSM STOP:   on fall, go to IDLE.
//   Frame good if stop==1 and the XOR of 8 data bits and the parity bit is 1.
//   Stop==0: frame_err pulse; scancode unchanged.
//   Stop OK but parity bad: parity_err pulse. If both are bad, only frame_err is raised.
// - Latency: scancode, scancode_valid, error pulses and key levels are all registered.
//   They update in the cycle after the stop-bit fall.
// - Timeout: a counter clears on every fall and counts while the FSM is not IDLE.
//   When it reaches TIMEOUT_CYCLES-1: frame_err pulse, go to IDLE, clear ext and brk.
// - Decode runs on each good byte, in the same cycle as scancode_valid:
//   - E0: set ext. Repeated E0 keeps ext set.
//   - F0: set brk.
//   - Any other byte: if ext is set and the byte is 74/6B/75, the matching key is set to ~brk;
//     otherwise the key levels are unchanged. Then clear ext and brk.
//   - Non-extended 74/6B/75 (keypad) never change the keys.
// - A parity or frame error clears ext and brk; key levels are untouched.
// - Typematic repeats (the same make code again) keep the key at 1.
// - Synchronous reset in any state, including mid-frame, aborts the frame and restores reset values next cycle.
// TESTING
// (FILTER_LEN=4, TIMEOUT_CYCLES=1000; ps2_clk half-period 50 cycles, data changes at ps2_clk rising edge)
// 1. Frame for 0x1C, parity 0 -> scancode=0x1C, one scancode_valid pulse, no err, keys stay 0.
// 2. E0 74, then E0 F0 74 -> key_right rises after the 2nd byte and falls after the 3rd.
//    key_left and key_up stay 0; 5 valid pulses.
// 3. E0 75 with wrong parity on the 75 byte -> parity_err pulse, scancode=0xE0, key_up=0.
//    A following 75 alone leaves key_up=0.
// 4. 4 data bits sent, then ps2_clk held high 1000 cycles -> frame_err pulse, FSM back in IDLE.
//    A next clean 0x1C is received correctly.
// 5. Stop bit 0 on byte 0x6B -> frame_err only, no valid. Separately, a 2-cycle glitch on ps2_clk -> no bit taken.
// 6. reset=1 for 1 cycle after 5 bits of a frame, with key_up held -> all outputs 0.
//    The next full E0 6B frame sets key_left.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: turns arrow-key make/break codes into held key levels, exports last scancode.
// Latency: outputs registered, update the cycle after the filtered stop-bit fall (+2 sync +FILTER_LEN filter).
// Backpressure: none; device-to-host only, every good byte produces a one-cycle scancode_valid pulse.
//
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data async pins (idle high);
//        scancode/scancode_valid, parity_err/frame_err pulses, key_right/key_left/key_up levels.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       key_right,
    output logic       key_left,
    output logic       key_up
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          clk_prev;
    logic          fall, din;

    state_t        state, state_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic          par_bit, par_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          byte_good, p_err, f_err;
    logic          ext, brk;

    // Synchronise both pins, then require FILTER_LEN consecutive differing
    // samples before the accepted level flips.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
            clk_prev <= 1'b1;
        end else begin
            sync1    <= {ps2_data, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev & ~filt[0];
    assign din  = filt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tmo     <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
            par_bit <= par_nx;
            tmo     <= tmo_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        par_nx     = par_bit;
        tmo_nx     = '0;
        byte_good  = 1'b0;
        p_err      = 1'b0;
        f_err      = 1'b0;

        if (!fall && state != IDLE) tmo_nx = tmo + 1'b1;

        case (state)
            IDLE: begin
                // A high start bit is noise; ignore it silently.
                if (fall && !din) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_nx = {din, shift[7:1]};
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                    else                 bit_cnt_nx = bit_cnt + 3'd1;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_nx   = din;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_nx = IDLE;
                    // Stop-bit error masks parity error.
                    if (!din)                 f_err     = 1'b1;
                    else if (^{shift, par_bit}) byte_good = 1'b1;
                    else                      p_err     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A fall in the same cycle restarts the timer, so it wins over expiry.
        if (!fall && state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            f_err    = 1'b1;
            tmo_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scancode       <= '0;
            scancode_valid <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
            key_right      <= 1'b0;
            key_left       <= 1'b0;
            key_up         <= 1'b0;
            ext            <= 1'b0;
            brk            <= 1'b0;
        end else begin
            scancode_valid <= byte_good;
            parity_err     <= p_err;
            frame_err      <= f_err;
            if (p_err || f_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_good) begin
                scancode <= shift;
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    // Only E0-prefixed arrows drive keys; keypad codes fall through.
                    if (ext) begin
                        case (shift)
                            8'h74:   key_right <= ~brk;
                            8'h6B:   key_left  <= ~brk;
                            8'h75:   key_up    <= ~brk;
                            default: ;
                        endcase
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomized + directed bench for ps2_keyboard_rx against a byte-level reference model.
// Latency: checks taken 20 cycles after each frame's final ps2_clk rise.
// Backpressure: not applicable; pulses counted at every falling clk edge.
module tb_ps2_keyboard_rx;
    localparam int FL = 4;
    localparam int TO = 1000;
    localparam int HP = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid, parity_err, frame_err;
    logic       key_right, key_left, key_up;

    int total = 0;
    int bad   = 0;

    // observed pulse counts
    int n_vld = 0, n_perr = 0, n_ferr = 0;
    // reference model state
    int         m_vld = 0, m_perr = 0, m_ferr = 0;
    logic [7:0] m_sc = 8'h00;
    bit         m_ext = 0, m_brk = 0, m_kr = 0, m_kl = 0, m_ku = 0;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .scancode_valid(scancode_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .key_right(key_right), .key_left(key_left), .key_up(key_up)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scancode_valid) n_vld++;
        if (parity_err)     n_perr++;
        if (frame_err)      n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: one complete frame at byte level.
    task automatic model_frame(input logic [7:0] b, input bit pb, input bit sb);
        if (sb) begin
            m_ferr++; m_ext = 0; m_brk = 0;
        end else if (pb) begin
            m_perr++; m_ext = 0; m_brk = 0;
        end else begin
            m_vld++;
            m_sc = b;
            if (b == 8'hE0)      m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                if (m_ext) begin
                    if (b == 8'h74) m_kr = !m_brk;
                    if (b == 8'h6B) m_kl = !m_brk;
                    if (b == 8'h75) m_ku = !m_brk;
                end
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    // Send the first nbits of a frame (11 = whole frame). If glitch_at >= 0,
    // a 2-cycle low pulse is put on ps2_clk during that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input bit pb, input bit sb,
                              input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits = {~sb, (~^b) ^ pb, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                wait_cyc(20);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(HP - 22);
            end else begin
                wait_cyc(HP);
            end
            ps2_clk = 1'b0;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) ps2_data = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sc"},   scancode,  m_sc);
        chk({tag, ".kr"},   key_right, m_kr);
        chk({tag, ".kl"},   key_left,  m_kl);
        chk({tag, ".ku"},   key_up,    m_ku);
        chk({tag, ".vld"},  n_vld,  m_vld);
        chk({tag, ".perr"}, n_perr, m_perr);
        chk({tag, ".ferr"}, n_ferr, m_ferr);
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit pb, input bit sb);
        send_frame(b, pb, sb, 11, -1);
        model_frame(b, pb, sb);
        wait_cyc(20);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] pool [6];
        pool = '{8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h75, 8'h1C};

        wait_cyc(10);
        chk("rst.sc",  scancode, 8'h00);
        chk("rst.vld", scancode_valid, 1'b0);
        chk("rst.perr", parity_err, 1'b0);
        chk("rst.ferr", frame_err, 1'b0);
        chk("rst.keys", {key_right, key_left, key_up}, 3'b000);
        reset = 1'b0;
        wait_cyc(10);

        // 1: plain byte
        frame("t1", 8'h1C, 0, 0);

        // 2: right arrow make then break
        frame("t2a", 8'hE0, 0, 0);
        frame("t2b", 8'h74, 0, 0);
        chk("t2.kr_make", key_right, 1'b1);
        frame("t2c", 8'hE0, 0, 0);
        frame("t2d", 8'hF0, 0, 0);
        frame("t2e", 8'h74, 0, 0);
        chk("t2.kr_break", key_right, 1'b0);

        // 3: parity error drops the E0 prefix
        frame("t3a", 8'hE0, 0, 0);
        frame("t3b", 8'h75, 1, 0);
        frame("t3c", 8'h75, 0, 0);
        chk("t3.ku", key_up, 1'b0);

        // 4: truncated frame then timeout
        send_frame(8'h5A, 0, 0, 5, -1);
        ps2_data = 1'b1;
        wait_cyc(TO + 200);
        m_ferr++; m_ext = 0; m_brk = 0;
        check_all("t4.tmo");
        frame("t4b", 8'h1C, 0, 0);

        // 5: bad stop bit, then a glitch mid-frame that must not be taken as a bit
        frame("t5a", 8'h6B, 0, 1);
        send_frame(8'hA5, 0, 0, 11, 3);
        model_frame(8'hA5, 0, 0);
        wait_cyc(20);
        check_all("t5.glitch");

        // 6: reset mid-frame with key_up held
        frame("t6a", 8'hE0, 0, 0);
        frame("t6b", 8'h75, 0, 0);
        chk("t6.ku_held", key_up, 1'b1);
        send_frame(8'h33, 0, 0, 6, -1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        ps2_data = 1'b1;
        m_sc = 8'h00; m_kr = 0; m_kl = 0; m_ku = 0; m_ext = 0; m_brk = 0;
        wait_cyc(2);
        check_all("t6.rst");
        wait_cyc(20);
        frame("t6c", 8'hE0, 0, 0);
        frame("t6d", 8'h6B, 0, 0);
        chk("t6.kl", key_left, 1'b1);

        // random traffic
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            bit pb, sb;
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else                           b = pool[$urandom_range(0, 5)];
            pb = ($urandom_range(0, 7) == 0);
            sb = ($urandom_range(0, 9) == 0);
            frame($sformatf("rnd%0d", k), b, pb, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
